// File: rtl/tick_debounce.sv
// Debounces one asynchronous input against a periodic tick: the synchronised level must hold
// for STABLE_TICKS counted ticks before the clean level flips, with one-cycle rise/fall pulses.
module tick_debounce #(
    parameter int STABLE_TICKS = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_in,
    output logic level_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_PEND_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_PEND_LOW  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_s;
    logic [CW:0]            cnt_inc_s;
    logic                   cnt_done_s;
    logic                   rise_d;
    logic                   fall_d;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    assign s_s        = sync_q[SYNC_STAGES-1];
    assign cnt_inc_s  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign cnt_done_s = (cnt_inc_s == (CW + 1)'(STABLE_TICKS));

    // Metastability synchroniser for the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Next-state logic; a level change back to the settled value abandons qualification
    // even when a tick arrives in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s_s) begin
                    state_d = ST_PEND_HIGH;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_PEND_HIGH: begin
                if (!s_s) begin
                    state_d = ST_LOW;
                    cnt_d   = {CW{1'b0}};
                end else if (tick) begin
                    if (cnt_done_s) begin
                        state_d = ST_HIGH;
                        cnt_d   = {CW{1'b0}};
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s[CW-1:0];
                    end
                end else begin
                    state_d = ST_PEND_HIGH;
                end
            end
            ST_HIGH: begin
                if (!s_s) begin
                    state_d = ST_PEND_LOW;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_PEND_LOW: begin
                if (s_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = {CW{1'b0}};
                end else if (tick) begin
                    if (cnt_done_s) begin
                        state_d = ST_LOW;
                        cnt_d   = {CW{1'b0}};
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s[CW-1:0];
                    end
                end else begin
                    state_d = ST_PEND_LOW;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (state_d == ST_HIGH) || (state_d == ST_PEND_LOW);
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= (state_d == ST_PEND_HIGH) || (state_d == ST_PEND_LOW);
        end
    end

    assign level_out = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign busy      = busy_q;

endmodule
